// File: rtl/reflet_vga_write_arbiter.sv
// ---------------------------------------------------------------------------
// reflet_vga_write_arbiter
//
// Shares the single write port of reflet_VGA between two requesters (for
// example a CPU bus bridge and a fill/blit engine). Each requester offers one
// bitmap-pixel or text-cell write at a time. A round-robin arbiter picks one
// command, registers it, holds the matching VGA write strobe for write_hold
// cycles, then optionally idles for gap_cycles before the next grant.
//
// Handshake: a requester raises rN_valid with a stable command and keeps it
// stable until the cycle in which rN_ready is high; the command is taken on
// the clock edge where rN_valid && rN_ready. rN_ready is combinational, only
// ever high in IDLE, never high during reset, and at most one requester sees
// ready in any cycle. Dropping valid before ready is allowed and has no effect.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   rN_valid / rN_ready         request handshake, N = 0,1
//   rN_is_txt                   1: text-cell write, 0: bitmap-pixel write
//   rN_h, rN_v                  coordinate of the pixel or cell
//   rN_fg                       {R,G,B,a} foreground
//   rN_bg                       {R,G,B} background (text only)
//   rN_char                     character code (text only)
//   write_bitmap, write_txt     strobes into reflet_VGA (never both high)
//   h_pixel, v_pixel            registered coordinate
//   R_in/G_in/B_in/a_in         registered foreground, unpacked
//   R_bg_in/G_bg_in/B_bg_in     registered background, unpacked
//   char_in                     registered character code
//   busy                        high whenever the arbiter is not IDLE
//   grant_id                    requester of the last accepted command
//   dbg_state_o                 current FSM state (0 IDLE, 1 WRITE, 2 GAP)
// ---------------------------------------------------------------------------
module reflet_vga_write_arbiter #(
  parameter int color_depth = 2,
  parameter int h_bits      = 7,
  parameter int v_bits      = 6,
  parameter int write_hold  = 1,
  parameter int gap_cycles  = 0
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     r0_valid,
  output logic                     r0_ready,
  input  logic                     r0_is_txt,
  input  logic [h_bits-1:0]        r0_h,
  input  logic [v_bits-1:0]        r0_v,
  input  logic [4*color_depth-1:0] r0_fg,
  input  logic [3*color_depth-1:0] r0_bg,
  input  logic [7:0]               r0_char,

  input  logic                     r1_valid,
  output logic                     r1_ready,
  input  logic                     r1_is_txt,
  input  logic [h_bits-1:0]        r1_h,
  input  logic [v_bits-1:0]        r1_v,
  input  logic [4*color_depth-1:0] r1_fg,
  input  logic [3*color_depth-1:0] r1_bg,
  input  logic [7:0]               r1_char,

  output logic                     write_bitmap,
  output logic                     write_txt,
  output logic [h_bits-1:0]        h_pixel,
  output logic [v_bits-1:0]        v_pixel,
  output logic [color_depth-1:0]   R_in,
  output logic [color_depth-1:0]   G_in,
  output logic [color_depth-1:0]   B_in,
  output logic [color_depth-1:0]   a_in,
  output logic [color_depth-1:0]   R_bg_in,
  output logic [color_depth-1:0]   G_bg_in,
  output logic [color_depth-1:0]   B_bg_in,
  output logic [7:0]               char_in,
  output logic                     busy,
  output logic                     grant_id,
  output logic [1:0]               dbg_state_o
);

  localparam int FG_W = 4 * color_depth;
  localparam int BG_W = 3 * color_depth;

  // A zero hold would never strobe, so it is widened to a single cycle.
  localparam int HOLD_EFF = (write_hold < 1) ? 1 : write_hold;

  // One down-counter serves both WRITE and GAP; it only has to reach the
  // larger of the two load values.
  localparam int CNT_MAX = (HOLD_EFF > gap_cycles) ? HOLD_EFF : gap_cycles;
  localparam int CNT_W   = (CNT_MAX <= 1) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (gap_cycles > 0) ? CNT_W'(gap_cycles - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;

  logic             txt_q, txt_d;
  logic [h_bits-1:0] h_q, h_d;
  logic [v_bits-1:0] v_q, v_d;
  logic [FG_W-1:0]  fg_q, fg_d;
  logic [BG_W-1:0]  bg_q, bg_d;
  logic [7:0]       char_q, char_d;
  logic             gid_q, gid_d;

  logic             pick1;
  logic             can_accept;
  logic             accept;

  // -------------------------------------------------------------------------
  // Arbitration. pick1 selects requester 1: it wins when it is the only one
  // asking, or when both ask and the round-robin pointer favours it.
  // -------------------------------------------------------------------------
  always_comb begin
    pick1      = r1_valid && (!r0_valid || ptr_q);
    can_accept = (state_q == ST_IDLE) && !reset;
    r0_ready   = can_accept && r0_valid && !pick1;
    r1_ready   = can_accept && pick1;
    accept     = r0_ready || r1_ready;
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WRITE;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_WRITE: begin
        if (cnt_q == '0) begin
          if (gap_cycles > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Command register. Loaded only on an accept edge so the VGA inputs stay
  // stable through the strobe and keep their value in IDLE and GAP. The
  // pointer moves to the requester that lost, giving strict alternation
  // under contention.
  // -------------------------------------------------------------------------
  always_comb begin
    ptr_d  = ptr_q;
    gid_d  = gid_q;
    txt_d  = txt_q;
    h_d    = h_q;
    v_d    = v_q;
    fg_d   = fg_q;
    bg_d   = bg_q;
    char_d = char_q;
    if (accept) begin
      ptr_d = !pick1;
      gid_d = pick1;
      if (pick1) begin
        txt_d  = r1_is_txt;
        h_d    = r1_h;
        v_d    = r1_v;
        fg_d   = r1_fg;
        bg_d   = r1_bg;
        char_d = r1_char;
      end else begin
        txt_d  = r0_is_txt;
        h_d    = r0_h;
        v_d    = r0_v;
        fg_d   = r0_fg;
        bg_d   = r0_bg;
        char_d = r0_char;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= 1'b0;
      gid_q  <= 1'b0;
      txt_q  <= 1'b0;
      h_q    <= '0;
      v_q    <= '0;
      fg_q   <= '0;
      bg_q   <= '0;
      char_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      gid_q  <= gid_d;
      txt_q  <= txt_d;
      h_q    <= h_d;
      v_q    <= v_d;
      fg_q   <= fg_d;
      bg_q   <= bg_d;
      char_q <= char_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Strobes are decoded from the registered state, so a reset edge
  // drops them immediately and an abandoned command is never replayed.
  // -------------------------------------------------------------------------
  always_comb begin
    write_bitmap = (state_q == ST_WRITE) && !txt_q;
    write_txt    = (state_q == ST_WRITE) && txt_q;
    busy         = (state_q != ST_IDLE);
    grant_id     = gid_q;
    dbg_state_o  = state_q;
    h_pixel      = h_q;
    v_pixel      = v_q;
    char_in      = char_q;
    R_in         = fg_q[4*color_depth-1 -: color_depth];
    G_in         = fg_q[3*color_depth-1 -: color_depth];
    B_in         = fg_q[2*color_depth-1 -: color_depth];
    a_in         = fg_q[color_depth-1:0];
    R_bg_in      = bg_q[3*color_depth-1 -: color_depth];
    G_bg_in      = bg_q[2*color_depth-1 -: color_depth];
    B_bg_in      = bg_q[color_depth-1:0];
  end

endmodule
